// File: rtl/spi_segment_sequencer.sv
// SPI-slave command front-end and 7-segment display scheduler.
// 16-bit frames load a 4-entry pattern buffer and set length, dwell, run and blink; MISO returns status.
module spi_segment_sequencer #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] seg,
  output logic       err
);

  logic [1:0]  sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic        sclk_prev_r, cs_prev_r;
  logic        sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

  logic        in_frame_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] rx_sh_r;
  logic [7:0]  tx_sh_r;
  logic        miso_r;

  logic [7:0]  pattern_r [4];
  logic [1:0]  len_m1_r;
  logic        run_r, blink_r, err_r;
  logic [7:0]  dwell_r;
  logic [1:0]  ptr_r;
  logic [23:0] presc_r;
  logic [7:0]  dwell_cnt_r;
  logic        blink_phase_r;
  logic [7:0]  seg_r;

  logic        commit_s, good_s, bad_s;
  logic        wr_pat_s, wr_len_s, wr_mode_s, wr_dwell_s;
  logic [3:0]  op_s;
  logic [1:0]  idx_s;
  logic [7:0]  data_s;
  logic [7:0]  status_s;
  logic [1:0]  len_m1_nxt_s, ptr_adv_s;
  logic        shrink_s, run_start_s, count_en_s, tick_s, dwell_hit_s, step_s;
  logic        unused_s;

  // Synchronisers and edge history; cs_n is taken as low out of reset so a fresh fall starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b00;
      mosi_sync_r <= 2'b00;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      cs_sync_r   <= {cs_sync_r[0], cs_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sclk_prev_r <= sclk_sync_r[1];
      cs_prev_r   <= cs_sync_r[1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
  assign cs_fall_s   = ~cs_sync_r[1] & cs_prev_r;
  assign cs_rise_s   = cs_sync_r[1] & ~cs_prev_r;

  assign status_s = {run_r, blink_r, err_r, 1'b0, len_m1_r, ptr_r};

  // Frame capture and status shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_r <= 1'b0;
      bit_cnt_r  <= 5'd0;
      rx_sh_r    <= 16'h0000;
      tx_sh_r    <= 8'h00;
      miso_r     <= 1'b0;
    end else if (cs_fall_s) begin
      in_frame_r <= 1'b1;
      bit_cnt_r  <= 5'd0;
      rx_sh_r    <= 16'h0000;
      tx_sh_r    <= {status_s[6:0], 1'b0};
      miso_r     <= status_s[7];
    end else if (cs_rise_s) begin
      in_frame_r <= 1'b0;
      miso_r     <= 1'b0;
    end else if (in_frame_r) begin
      if (sclk_rise_s) begin
        rx_sh_r <= {rx_sh_r[14:0], mosi_sync_r[1]};
        if (bit_cnt_r != 5'd31) begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
      end
      if (sclk_fall_s) begin
        miso_r  <= tx_sh_r[7];
        tx_sh_r <= {tx_sh_r[6:0], 1'b0};
      end
    end
  end

  assign commit_s = cs_rise_s & in_frame_r;
  assign op_s     = rx_sh_r[15:12];
  assign idx_s    = rx_sh_r[9:8];
  assign data_s   = rx_sh_r[7:0];
  assign unused_s = ^rx_sh_r[11:10];

  // Command decode at end of frame
  always_comb begin
    wr_pat_s   = 1'b0;
    wr_len_s   = 1'b0;
    wr_mode_s  = 1'b0;
    wr_dwell_s = 1'b0;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    if (commit_s) begin
      if (bit_cnt_r == 5'd16) begin
        good_s = 1'b1;
        case (op_s)
          4'h1:    wr_pat_s   = 1'b1;
          4'h2:    wr_len_s   = 1'b1;
          4'h3:    wr_mode_s  = 1'b1;
          4'h4:    wr_dwell_s = 1'b1;
          default: begin
            good_s = 1'b0;
            bad_s  = 1'b1;
          end
        endcase
      end else begin
        bad_s = 1'b1;
      end
    end else begin
      bad_s = 1'b0;
    end
  end

  // Configuration registers and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r[0] <= 8'h00;
      pattern_r[1] <= 8'h00;
      pattern_r[2] <= 8'h00;
      pattern_r[3] <= 8'h00;
      len_m1_r     <= 2'd0;
      run_r        <= 1'b0;
      blink_r      <= 1'b0;
      dwell_r      <= 8'd1;
      err_r        <= 1'b0;
    end else begin
      if (wr_pat_s) pattern_r[idx_s] <= data_s;
      if (wr_len_s) len_m1_r <= data_s[1:0];
      if (wr_mode_s) begin
        run_r   <= data_s[0];
        blink_r <= data_s[1];
      end
      if (wr_dwell_s) dwell_r <= (data_s == 8'h00) ? 8'h01 : data_s;
      if (bad_s) begin
        err_r <= 1'b1;
      end else if (good_s) begin
        err_r <= 1'b0;
      end
    end
  end

  // Advance wraps against the length in force after any same-cycle length write
  assign len_m1_nxt_s = wr_len_s ? data_s[1:0] : len_m1_r;
  assign ptr_adv_s    = (ptr_r == len_m1_nxt_s) ? 2'd0 : ptr_r + 2'd1;
  assign shrink_s     = wr_len_s && (ptr_r > data_s[1:0]);
  assign run_start_s  = wr_mode_s && data_s[0] && !run_r;
  assign count_en_s   = run_r | blink_r;
  assign tick_s       = count_en_s && (presc_r == (TICK_DIV - 24'd1));
  assign dwell_hit_s  = ({1'b0, dwell_cnt_r} + 9'd1) == {1'b0, dwell_r};
  assign step_s       = tick_s && run_r;

  // Timebase, dwell counting, pointer stepping and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= 24'd0;
      dwell_cnt_r   <= 8'd0;
      ptr_r         <= 2'd0;
      blink_phase_r <= 1'b0;
    end else begin
      if (run_start_s) begin
        presc_r <= 24'd0;
      end else if (count_en_s) begin
        presc_r <= tick_s ? 24'd0 : presc_r + 24'd1;
      end
      if (run_start_s) begin
        dwell_cnt_r <= 8'd0;
      end else if (step_s) begin
        dwell_cnt_r <= dwell_hit_s ? 8'd0 : dwell_cnt_r + 8'd1;
      end
      if (shrink_s) begin
        ptr_r <= 2'd0;
      end else if (step_s && dwell_hit_s) begin
        ptr_r <= ptr_adv_s;
      end
      if (!blink_r) begin
        blink_phase_r <= 1'b0;
      end else if (tick_s) begin
        blink_phase_r <= ~blink_phase_r;
      end
    end
  end

  // Registered segment bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 8'h00;
    end else begin
      seg_r <= blink_phase_r ? 8'h00 : pattern_r[ptr_r];
    end
  end

  assign seg  = seg_r;
  assign miso = miso_r;
  assign err  = err_r;

endmodule

// File: tb/tb_spi_segment_sequencer.sv
// Directed bench for spi_segment_sequencer with TICK_DIV=4; SPI driven at 12 clk per sclk period.
module tb_spi_segment_sequencer;

  localparam logic [23:0] TD = 24'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       err;
  logic [7:0] seg;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_segment_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .seg(seg), .err(err)
  );

  task automatic spi_xfer(input logic [15:0] tx, input int nbits, input bit hold, output logic [7:0] rx);
    rx = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    #60;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[15-i];
      #60;
      if (i < 8) rx[7-i] = miso;
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
    end
    #60;
    if (!hold) begin
      cs_n = 1'b1;
      #60;
    end
  endtask

  task automatic send(input logic [15:0] tx);
    logic [7:0] d;
    spi_xfer(tx, 16, 1'b0, d);
  endtask

  task automatic test_reset;
    logic [7:0] rx;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (seg !== 8'h00) begin n_bad++; $display("FAIL reset_seg: got %h want 00", seg); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    spi_xfer(16'h2000, 16, 1'b0, rx);
    n_cmp++; if (rx !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h want 00", rx); end
    n_cmp++; if (seg !== 8'h00) begin n_bad++; $display("FAIL reset_seg_after_read: got %h want 00", seg); end
  endtask

  task automatic test_sequence;
    bit found;
    logic [7:0] exp;
    send(16'h103F);
    send(16'h1106);
    send(16'h2101);
    send(16'h4002);
    n_cmp++; if (seg !== 8'h3F) begin n_bad++; $display("FAIL seq_idle_seg: got %h want 3f", seg); end
    send(16'h3001);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (seg !== 8'h3F) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL seq_first_step: got no change want change within 40 clk"); end
    for (int i = 0; i < 24; i++) begin
      exp = (((i / 8) % 2) == 0) ? 8'h06 : 8'h3F;
      n_cmp++; if (seg !== exp) begin n_bad++; $display("FAIL seq_cycle%0d: got %h want %h", i, seg, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_short_frame;
    logic [7:0] rx;
    send(16'h3000);
    send(16'h2100);
    repeat (4) @(negedge clk);
    n_cmp++; if (seg !== 8'h3F) begin n_bad++; $display("FAIL short_pre_seg: got %h want 3f", seg); end
    spi_xfer(16'h1099, 12, 1'b0, rx);
    repeat (4) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b want 1", err); end
    n_cmp++; if (seg !== 8'h3F) begin n_bad++; $display("FAIL short_seg: got %h want 3f", seg); end
    send(16'h105B);
    repeat (4) @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL short_recover_err: got %b want 0", err); end
    n_cmp++; if (seg !== 8'h5B) begin n_bad++; $display("FAIL short_recover_seg: got %h want 5b", seg); end
  endtask

  task automatic test_bad_opcode;
    logic [7:0] rx;
    send(16'h70AA);
    repeat (4) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL badop_err: got %b want 1", err); end
    n_cmp++; if (seg !== 8'h5B) begin n_bad++; $display("FAIL badop_seg: got %h want 5b", seg); end
    spi_xfer(16'h2000, 16, 1'b0, rx);
    n_cmp++; if (rx !== 8'h20) begin n_bad++; $display("FAIL badop_status: got %h want 20", rx); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL badop_clear: got %b want 0", err); end
  endtask

  task automatic test_len_shrink_tick;
    logic [7:0] rx;
    bit found;
    int cyc_det;
    send(16'h1106);
    send(16'h124F);
    send(16'h1366);
    send(16'h2103);
    send(16'h40FF);
    send(16'h3001);
    found = 1'b0;
    cyc_det = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (seg === 8'h66) begin found = 1'b1; cyc_det = cyc; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL shrink_reach_ptr3: got no 66 want 66 within 5000 clk"); end
    spi_xfer(16'h2001, 16, 1'b1, rx);
    // ptr moved at posedge cyc_det-1; ticks recur every 4, commit lands 3 posedges after cs_n rises
    for (int k = 0; k < 4; k++) begin
      if (((cyc + 4 - cyc_det) % 4) == 0) break;
      @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++; if (seg !== 8'h5B) begin n_bad++; $display("FAIL shrink_seg: got %h want 5b", seg); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL shrink_err: got %b want 0", err); end
  endtask

  task automatic test_blink;
    logic [7:0] first, cur0, alt, exp;
    bit found;
    send(16'h3002);
    @(negedge clk);
    first = seg;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (seg !== first) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL blink_toggle: got no change want change within 20 clk"); end
    cur0 = seg;
    n_cmp++; if (cur0 !== 8'h00 && cur0 !== 8'h5B) begin n_bad++; $display("FAIL blink_value: got %h want 00 or 5b", cur0); end
    alt = (cur0 === 8'h00) ? 8'h5B : 8'h00;
    for (int i = 0; i < 16; i++) begin
      exp = (((i / 4) % 2) == 0) ? cur0 : alt;
      n_cmp++; if (seg !== exp) begin n_bad++; $display("FAIL blink_cycle%0d: got %h want %h", i, seg, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rx;
    logic [15:0] part;
    send(16'h3000);
    repeat (4) @(negedge clk);
    n_cmp++; if (seg !== 8'h5B) begin n_bad++; $display("FAIL midrst_pre_seg: got %h want 5b", seg); end
    part = 16'h10FF;
    @(negedge clk);
    cs_n = 1'b0;
    #60;
    for (int i = 0; i < 6; i++) begin
      mosi = part[15-i];
      #60;
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (seg !== 8'h00) begin n_bad++; $display("FAIL midrst_seg: got %h want 00", seg); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL midrst_miso: got %b want 0", miso); end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (seg !== 8'h00) begin n_bad++; $display("FAIL midrst_after_seg: got %h want 00", seg); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_after_err: got %b want 0", err); end
    send(16'h1077);
    repeat (4) @(negedge clk);
    n_cmp++; if (seg !== 8'h77) begin n_bad++; $display("FAIL midrst_frame_seg: got %h want 77", seg); end
    spi_xfer(16'h2000, 16, 1'b0, rx);
    n_cmp++; if (rx !== 8'h00) begin n_bad++; $display("FAIL midrst_status: got %h want 00", rx); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_short_frame();
    test_bad_opcode();
    test_len_shrink_tick();
    test_blink();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
